sprite_rom_arbiter: RTL and testbench

//  Round-robin arbiter that shares one synchronous sprite ROM among NUM_REQ pixel-fetch requesters.

---
 rtl/sprite_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ requesters.
// Define SPRITE_ARB_BOUNDS_EN to trap addresses >= DEPTH (rom_addr 0, err flagged, rdata 0).
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 5,
  parameter int DEPTH   = 550,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ-1:0]        err
);

  localparam int          ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ   = NUM_REQ;
  localparam int unsigned STAGES = ROM_LAT + 1;

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (ROM_LAT < 1) || (ROM_LAT > 4) || (DEPTH < 1))
    begin : g_bad_param
      $error("sprite_rom_arbiter: parameter out of supported range");
    end

  typedef struct packed {
    logic            valid;
`ifdef SPRITE_ARB_BOUNDS_EN
    logic            err;
`endif
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0] r_rom_addr;
  tag_t              r_tag [STAGES];

  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic [ADDR_W-1:0] w_sel_addr;
  tag_t              w_new_tag;
  tag_t              w_last;

  // Search starts one past the last winner so the previous winner ends up last in line.
  always_comb begin
    int unsigned v_idx;
    w_any = 1'b0;
    w_win = '0;
    gnt   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      v_idx = (32'(r_rr_ptr) + off) % NREQ;
      if (!w_any && req[v_idx]) begin
        w_any      = 1'b1;
        w_win      = ID_W'(v_idx);
        gnt[v_idx] = 1'b1;
      end
    end
  end

  assign w_sel_addr = addr[w_win*ADDR_W +: ADDR_W];

`ifdef SPRITE_ARB_BOUNDS_EN
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  logic w_oob;
  assign w_oob = ({1'b0, w_sel_addr} >= DEPTH_A);

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_any;
    w_new_tag.err   = w_any && w_oob;
    w_new_tag.id    = w_win;
  end
`else
  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_any;
    w_new_tag.id    = w_win;
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_rom_addr <= '0;
      for (int unsigned i = 0; i < STAGES; i++) r_tag[i] <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr <= w_win;
`ifdef SPRITE_ARB_BOUNDS_EN
        r_rom_addr <= w_oob ? '0 : w_sel_addr;
`else
        r_rom_addr <= w_sel_addr;
`endif
      end
      r_tag[0] <= w_new_tag;
      for (int unsigned i = 1; i < STAGES; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign rom_addr = r_rom_addr;
  assign w_last   = r_tag[STAGES-1];

  always_comb begin
    rvalid = '0;
    err    = '0;
    rdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      rvalid[i] = w_last.valid && (w_last.id == ID_W'(i));
`ifdef SPRITE_ARB_BOUNDS_EN
    err = w_last.err ? rvalid : '0;
    if (w_last.valid && !w_last.err) rdata = rom_data;
`else
    if (w_last.valid) rdata = rom_data;
`endif
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed table-driven bench for sprite_rom_arbiter (NUM_REQ=2, ROM_LAT=1) with a behavioural ROM.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 5;

  logic                      Clk;
  logic                      Reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rvalid;
  logic [NUM_REQ-1:0]        err;

  logic [ADDR_W-1:0] a0, a1;
  assign addr = {a1, a0};

  int n_total = 0;
  int n_pass  = 0;

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (550),
    .ROM_LAT(1)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req     (req),
    .addr    (addr),
    .gnt     (gnt),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .err     (err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [DATA_W-1:0] romf(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd3 + 32'd1;
    return t[DATA_W-1:0];
  endfunction

  // One-cycle synchronous ROM
  always_ff @(posedge Clk) rom_data <= romf(rom_addr);

  typedef struct {
    logic [1:0]        req;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] raddr;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] r, input int x0, input int x1,
                              input logic [1:0] g, input logic [1:0] v,
                              input logic [DATA_W-1:0] d, input int ra);
    vec_t t;
    t.req = r; t.a0 = ADDR_W'(x0); t.a1 = ADDR_W'(x1);
    t.gnt = g; t.rvalid = v; t.rdata = d; t.raddr = ADDR_W'(ra);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  vec_t tv [27];

  initial begin
    // Continuous stream after reset release: single request, contention, back-to-back, withdrawn request.
    tv[0]  = mk(2'b11, 40, 60,  2'b01, 2'b00, 5'd0,        0);
    tv[1]  = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        40);
    tv[2]  = mk(2'b00, 0,  0,   2'b00, 2'b01, romf(40),    40);
    tv[3]  = mk(2'b01, 17, 0,   2'b01, 2'b00, 5'd0,        40);
    tv[4]  = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        17);
    tv[5]  = mk(2'b00, 0,  0,   2'b00, 2'b01, romf(17),    17);
    tv[6]  = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        17);
    tv[7]  = mk(2'b11, 5,  300, 2'b10, 2'b00, 5'd0,        17);
    tv[8]  = mk(2'b11, 5,  300, 2'b01, 2'b00, 5'd0,        300);
    tv[9]  = mk(2'b11, 5,  300, 2'b10, 2'b10, romf(300),   5);
    tv[10] = mk(2'b11, 5,  300, 2'b01, 2'b01, romf(5),     300);
    tv[11] = mk(2'b11, 5,  300, 2'b10, 2'b10, romf(300),   5);
    tv[12] = mk(2'b11, 5,  300, 2'b01, 2'b01, romf(5),     300);
    tv[13] = mk(2'b00, 0,  0,   2'b00, 2'b10, romf(300),   5);
    tv[14] = mk(2'b00, 0,  0,   2'b00, 2'b01, romf(5),     5);
    tv[15] = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        5);
    tv[16] = mk(2'b10, 0,  0,   2'b10, 2'b00, 5'd0,        5);
    tv[17] = mk(2'b10, 0,  1,   2'b10, 2'b00, 5'd0,        0);
    tv[18] = mk(2'b10, 0,  2,   2'b10, 2'b10, romf(0),     1);
    tv[19] = mk(2'b10, 0,  3,   2'b10, 2'b10, romf(1),     2);
    tv[20] = mk(2'b00, 0,  0,   2'b00, 2'b10, romf(2),     3);
    tv[21] = mk(2'b00, 0,  0,   2'b00, 2'b10, romf(3),     3);
    tv[22] = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        3);
    tv[23] = mk(2'b11, 8,  9,   2'b01, 2'b00, 5'd0,        3);
    tv[24] = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        8);
    tv[25] = mk(2'b00, 0,  0,   2'b00, 2'b01, romf(8),     8);
    tv[26] = mk(2'b00, 0,  0,   2'b00, 2'b00, 5'd0,        8);

    Reset_n = 1'b0;
    req = 2'b11; a0 = 19'd40; a1 = 19'd60;
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_gnt",      32'(gnt),      32'h1);
    chk("reset_rom_addr", 32'(rom_addr), 32'h0);
    chk("reset_rvalid",   32'(rvalid),   32'h0);
    chk("reset_rdata",    32'(rdata),    32'h0);
    chk("reset_err",      32'(err),      32'h0);

    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      req = tv[i].req; a0 = tv[i].a0; a1 = tv[i].a1;
      #1;
      chk($sformatf("v%0d_gnt", i),      32'(gnt),      32'(tv[i].gnt));
      chk($sformatf("v%0d_rvalid", i),   32'(rvalid),   32'(tv[i].rvalid));
      chk($sformatf("v%0d_rdata", i),    32'(rdata),    32'(tv[i].rdata));
      chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(tv[i].raddr));
      chk($sformatf("v%0d_err", i),      32'(err),      32'h0);
      @(negedge Clk);
    end

    // Reset one cycle after a grant: the in-flight access must never return.
    req = 2'b01; a0 = 19'd33;
    #1 chk("mid_gnt", 32'(gnt), 32'h1);
    @(negedge Clk);
    req = 2'b00; Reset_n = 1'b0;
    #1;
    chk("mid_rst_rvalid",   32'(rvalid),   32'h0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
    @(negedge Clk);
    req = 2'b11; a0 = 19'd70; a1 = 19'd71;
    #1;
    chk("mid_rst_rvalid2", 32'(rvalid), 32'h0);
    chk("mid_rst_gnt",     32'(gnt),    32'h1);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 chk("mid_rel_gnt", 32'(gnt), 32'h1);
    @(negedge Clk);
    req = 2'b00;
    #1;
    chk("mid_rel_rom_addr", 32'(rom_addr), 32'd70);
    chk("mid_rel_rvalid0",  32'(rvalid),   32'h0);
    @(negedge Clk);
    #1;
    chk("mid_rel_rvalid1", 32'(rvalid), 32'h1);
    chk("mid_rel_rdata",   32'(rdata),  32'(romf(19'd70)));

    // Address at and just below DEPTH.
    @(negedge Clk);
    req = 2'b01; a0 = 19'd550;
    #1 chk("oob_gnt", 32'(gnt), 32'h1);
    @(negedge Clk);
    a0 = 19'd549;
    #1;
    chk("edge_gnt", 32'(gnt), 32'h1);
`ifdef SPRITE_ARB_BOUNDS_EN
    chk("oob_rom_addr", 32'(rom_addr), 32'h0);
`else
    chk("oob_rom_addr", 32'(rom_addr), 32'd550);
`endif
    @(negedge Clk);
    req = 2'b00;
    #1;
    chk("edge_rom_addr", 32'(rom_addr), 32'd549);
    chk("oob_rvalid",    32'(rvalid),   32'h1);
`ifdef SPRITE_ARB_BOUNDS_EN
    chk("oob_err",   32'(err),   32'h1);
    chk("oob_rdata", 32'(rdata), 32'h0);
`else
    chk("oob_err",   32'(err),   32'h0);
    chk("oob_rdata", 32'(rdata), 32'(romf(19'd550)));
`endif
    @(negedge Clk);
    #1;
    chk("edge_rvalid", 32'(rvalid), 32'h1);
    chk("edge_err",    32'(err),    32'h0);
    chk("edge_rdata",  32'(rdata),  32'(romf(19'd549)));
    @(negedge Clk);
    #1;
    chk("tail_rvalid", 32'(rvalid), 32'h0);
    chk("tail_err",    32'(err),    32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
